// File: rtl/serial_tx4_if.sv
// rtl/serial_tx4_if.sv - word handshake between a producer and serial_tx4
//
// Purpose: groups the valid/ready word offer into one bundle.
// Signals:
//   in_valid  producer offers a word
//   in_data   DATA_W-bit word to serialize
//   in_left   direction sampled with the word (0 = right/LSB first, 1 = left/MSB first)
//   in_ready  consumer can accept a word
// Modports: master = producer side, slave = serial_tx4 side.
interface serial_tx4_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_left;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_left, input in_ready);
  modport slave  (input in_valid, input in_data, input in_left, output in_ready);
endinterface

// File: rtl/serial_tx4.sv
// rtl/serial_tx4.sv - parallel-to-serial sequencer feeding a 4-bit universal shift register
//
// Purpose: accepts a DATA_W-bit word and replays it one bit per cycle on the
// serial-entry side of a downstream shift register (sr/ir or sl/il), so that
// after the last strobe the register holds exactly the accepted word.
// Optional feature: define SERIAL_TX_CLEAR_EN to add a one-cycle CLR state
// that pulses cl before every transfer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_if       slave side of the word handshake (in_valid/in_data/in_left/in_ready)
//   flush       synchronous abort back to IDLE, no done
//   cl          clear strobe to the downstream register
//   sr, ir      right-shift strobe and serial bit entering the register MSB
//   sl, il      left-shift strobe and serial bit entering the register LSB
//   busy        transfer in progress
//   done        one-cycle registered pulse after the last shift
module serial_tx4 #(
  parameter int DATA_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_tx4_if.slave  in_if,
  input  logic         flush,
  output logic         cl,
  output logic         sr,
  output logic         ir,
  output logic         sl,
  output logic         il,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

`ifdef SERIAL_TX_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              left;
  logic              done_nx;
  logic              ld;
  logic              shift_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
      left  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (ld) begin
        shreg <= in_if.in_data;
        left  <= in_if.in_left;
        cnt   <= '0;
      end else if (shift_en) begin
        // The bit just presented leaves the buffer; the next one moves to the exit end.
        shreg <= left ? (shreg << 1) : (shreg >> 1);
        cnt   <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    ld       = 1'b0;
    shift_en = 1'b0;
    if (flush) begin
      // Abort wins over everything, including an offer made while idle.
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_if.in_valid) begin
            ld = 1'b1;
`ifdef SERIAL_TX_CLEAR_EN
            state_nx = S_CLR;
`else
            state_nx = S_SHIFT;
`endif
          end
        end
`ifdef SERIAL_TX_CLEAR_EN
        S_CLR: state_nx = S_SHIFT;
`endif
        S_SHIFT: begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Outputs come from registered state only; the serial bits are gated by their strobe.
  assign in_if.in_ready = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign sr             = (state == S_SHIFT) && !left;
  assign sl             = (state == S_SHIFT) && left;
  assign ir             = sr & shreg[0];
  assign il             = sl & shreg[DATA_W-1];
`ifdef SERIAL_TX_CLEAR_EN
  assign cl             = (state == S_CLR);
`else
  assign cl             = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx4.sv
// tb/tb_serial_tx4.sv - randomized self-checking bench for serial_tx4
module tb_serial_tx4;
  localparam int W = 4;
`ifdef SERIAL_TX_CLEAR_EN
  localparam bit HAS_CLR = 1'b1;
`else
  localparam bit HAS_CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cl, sr, ir, sl, il, busy, done;
  int   checks = 0;
  int   errors = 0;

  serial_tx4_if #(.DATA_W(W)) bus ();

  serial_tx4 #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (bus),
    .flush (flush),
    .cl    (cl),
    .sr    (sr),
    .ir    (ir),
    .sl    (sl),
    .il    (il),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register: what the serial stream builds up.
  logic [W-1:0] dreg = '0;
  logic [W-1:0] pre_val = '0;
  logic         pre_en = 1'b0;
  always @(posedge clk) begin
    if (pre_en)  dreg <= pre_val;
    else if (cl) dreg <= '0;
    else if (sr) dreg <= {ir, dreg[W-1:1]};
    else if (sl) dreg <= {dreg[W-2:0], il};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed vector: {sr, ir, sl, il, busy, in_ready, done, cl}
  function automatic logic [7:0] obs();
    return {sr, ir, sl, il, busy, bus.in_ready, done, cl};
  endfunction

  // From one cycle after acceptance through the done cycle.
  task automatic run_body(input logic [W-1:0] word, input logic left_m, input string tag);
    logic [7:0] exp;
    logic       b;
    if (HAS_CLR) begin
      checks++;
      if (obs() !== 8'b0000_1001) begin
        errors++;
        $display("FAIL %s clr_cycle: got %b required %b", tag, obs(), 8'b0000_1001);
      end
      step();
      checks++;
      if (dreg !== '0) begin
        errors++;
        $display("FAIL %s cleared_reg: got %h required 0", tag, dreg);
      end
    end
    for (int i = 0; i < W; i++) begin
      b   = left_m ? word[W-1-i] : word[i];
      exp = left_m ? {2'b00, 1'b1, b, 4'b1000} : {1'b1, b, 2'b00, 4'b1000};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL %s strobe%0d: got %b required %b", tag, i, obs(), exp);
      end
      step();
    end
    checks++;
    if (obs() !== 8'b0000_0110) begin
      errors++;
      $display("FAIL %s done_cycle: got %b required %b", tag, obs(), 8'b0000_0110);
    end
    checks++;
    if (dreg !== word) begin
      errors++;
      $display("FAIL %s reg_value: got %h required %h", tag, dreg, word);
    end
  endtask

  task automatic accept(input logic [W-1:0] word, input logic left_m, input string tag);
    int to;
    to = 0;
    while (bus.in_ready !== 1'b1 && to < 50) begin
      step();
      to++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: got %b required 1", tag, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    bus.in_left  = left_m;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    bus.in_left  = 1'($urandom);
  endtask

  task automatic xfer(input logic [W-1:0] word, input logic left_m, input string tag);
    accept(word, left_m, tag);
    run_body(word, left_m, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (obs() !== 8'b0000_0100) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", obs(), 8'b0000_0100);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (obs() !== 8'b0000_0100) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required %b", obs(), 8'b0000_0100);
    end
  endtask

  task automatic test_directed();
    xfer(4'b1011, 1'b0, "right_1011");
    step();
    xfer(4'b1011, 1'b1, "left_1011");
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      xfer(W'($urandom), 1'($urandom), "random");
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic test_back_to_back();
    accept(4'hA, 1'b0, "b2b_first");
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h5;
    bus.in_left  = 1'b0;
    run_body(4'hA, 1'b0, "b2b_first");
    step();
    bus.in_valid = 1'b0;
    run_body(4'h5, 1'b0, "b2b_second");
    step();
  endtask

  task automatic test_flush();
    logic [W-1:0] w;
    logic         lm;
    w  = W'($urandom);
    lm = 1'($urandom);
    accept(w, lm, "flush");
    if (HAS_CLR) step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (obs() !== 8'b0000_0100) begin
      errors++;
      $display("FAIL flush_abort: got %b required %b", obs(), 8'b0000_0100);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({sr, sl, done} !== 3'b000) begin
        errors++;
        $display("FAIL flush_quiet%0d: got %b required 000", i, {sr, sl, done});
      end
      step();
    end
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h7;
    step();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (obs() !== 8'b0000_0100) begin
      errors++;
      $display("FAIL flush_idle_priority: got %b required %b", obs(), 8'b0000_0100);
    end
    xfer(4'h3, 1'b0, "after_flush");
    step();
  endtask

  task automatic test_reset_mid();
    accept(4'hC, 1'b1, "reset_mid");
    if (HAS_CLR) step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'b0000_0100) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b required %b", obs(), 8'b0000_0100);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({sr, sl, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_quiet%0d: got %b required 000", i, {sr, sl, done});
      end
      step();
    end
    xfer(4'hF, 1'($urandom), "after_reset");
    step();
  endtask

  task automatic test_clear_preload();
    pre_val = 4'h9;
    pre_en  = 1'b1;
    step();
    pre_en  = 1'b0;
    checks++;
    if (dreg !== 4'h9) begin
      errors++;
      $display("FAIL preload: got %h required 9", dreg);
    end
    xfer(4'h6, 1'b0, "clear_preload");
    step();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_left  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_clear_preload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_tx4.md
# serial_tx4

Parallel-to-serial sequencer that drives the serial-entry side of the team's 4-bit universal shift register. It accepts a DATA_W-bit word over a valid/ready handshake. It then emits the word one bit per cycle on `ir` or `il`, together with the matching `sr` or `sl` strobe. After the last strobe, a downstream register wired to these outputs holds exactly the accepted word. It sits between a word producer and one or more shift-register instances.

## Interface
- `DATA_W`, default 4: word width and number of shift cycles; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers a word.
- `in_data`  in  DATA_W  word to serialize.
- `in_left`  in  1  direction, sampled with the word: 0 = right-shift mode (`sr`/`ir`, LSB first); 1 = left-shift mode (`sl`/`il`, MSB first).
- `flush`  in  1  synchronous abort.
- `in_ready`  out  1  block can accept a word.
- `cl`  out  1  clear strobe to the downstream register.
- `sr`, `ir`  out  1 each  right-shift strobe and the serial bit that enters the register MSB.
- `sl`, `il`  out  1 each  left-shift strobe and the serial bit that enters the register LSB.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse after the last shift.

## Operation
- States: IDLE, CLR (present only with the macro), SHIFT.
- IDLE: `in_ready`=1. When `in_valid`&&`in_ready` at edge N:
  - latch `in_data` into the shift buffer and `in_left` into the mode flag;
  - clear the bit counter;
  - go to CLR, or to SHIFT when the macro is absent.
- CLR: `cl`=1 for exactly one cycle, then go to SHIFT.
- SHIFT: one strobe per cycle for DATA_W cycles.
  - Right mode: `sr`=1 and `ir`=buf[0]; buffer shifts right.
  - Left mode: `sl`=1 and `il`=buf[DATA_W-1]; buffer shifts left.
  - The counter (width clog2(DATA_W)) increments on each strobe.
  - At count DATA_W-1: return to IDLE and set `done` for the next cycle.
- Only one of `sr`/`sl` is ever high. The unused serial bit and both strobes are 0 outside SHIFT. `ir`/`il` are 0 whenever their strobe is 0.
- `busy` = state ≠ IDLE. `in_ready` = state == IDLE.
- `in_valid` is ignored while busy; the producer must hold the word until accepted.
- `flush`:
  - In any state, the next state is IDLE with no `done` and no further strobes.
  - In IDLE, `flush` has priority over acceptance: nothing is accepted that cycle.
- All outputs are decoded from registered state only, with no combinational path from inputs. `done` is a registered flop.
- Reset values: state IDLE, buffer 0, counter 0, `done`=0. So `in_ready`=1, and `busy`, `cl`, `sr`, `ir`, `sl`, `il` are all 0.
- Reset asserted mid-transfer aborts immediately: strobes drop asynchronously and no `done` is produced.

## Timing
- Macro absent: accept at edge N; strobes in cycles N+1…N+DATA_W; `done` and `in_ready`=1 in cycle N+DATA_W+1.
- Back-to-back: a new word can be accepted at the edge ending cycle N+DATA_W+1, so throughput is one word per DATA_W+1 cycles.
- Macro present: `cl` in cycle N+1; strobes in N+2…N+DATA_W+1; `done` in N+DATA_W+2.
- `done` can coincide with `in_ready`=1 and with a new acceptance.

## Configuration
- `SERIAL_TX_CLEAR_EN` defined:
  - The CLR state is compiled in, and every transfer starts with a one-cycle `cl` pulse.
  - The downstream register is zeroed even for partial (flushed) transfers.
- Not defined:
  - There is no CLR state; `cl` is tied to 0.
  - Latency is one cycle shorter.
  - Bits left in the downstream register by a flushed transfer stay there.

## Test plan
- Right mode, DATA_W=4, `in_data`=4'b1011, macro off → `ir` sequence 1,1,0,1 with `sr`=1 for 4 cycles; register model = 4'b1011; `done` at N+5.
- Left mode, `in_data`=4'b1011 → `il` sequence 1,0,1,1 with `sl`=1; register model = 4'b1011; `sr` stays 0 throughout.
- `in_valid` held high with words 4'hA then 4'h5 → second acceptance in the `done` cycle; register reads 4'hA, then 4'h5 four strobes later; no idle gap.
- `flush` in the 2nd SHIFT cycle → no further strobes, no `done`, `in_ready`=1 next cycle; a new word 4'h3 then completes normally.
- `rst_n` low mid-SHIFT → all strobes 0 immediately, `in_ready`=1, `done` never pulses; after release, 4'hF transfers correctly.
- Macro on, `in_data`=4'h6 with the register preloaded to 4'h9 → `cl` in N+1, strobes in N+2…N+5, register = 4'h6, `done` at N+6.
